// File: rtl/fifo_share_pkg.sv
// Shared constants, grant encoding and occupancy helper for the fifo_share_ctrl slice.
package fifo_share_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned UW_DEF    = 8;
    localparam int unsigned WMARK_DEF = 192;

    // Identity of the producer that won the most recent FIFO write.
    localparam logic GNT0 = 1'b0;
    localparam logic GNT1 = 1'b1;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_IN0  = 2'b01,
        GRANT_IN1  = 2'b10
    } grant_e;

    // Words held or in flight after this cycle's pop; 3 bits so the subtraction cannot wrap.
    function automatic logic [2:0] skid_occ(input logic [1:0] cnt, input logic pend, input logic pop);
        return {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_share_skid.sv
// Two-entry FIFO-ordered output buffer fed by the FIFO q port one cycle after rdreq.
module fifo_share_skid
    import fifo_share_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [1:0]    buf_cnt
);

    logic [DW-1:0] ent0;
    logic [DW-1:0] ent1;
    logic [DW-1:0] ent0_nxt;
    logic [DW-1:0] ent1_nxt;
    logic [1:0]    cnt_nxt;

    // ent0 is always the head; a pop shifts ent1 forward.
    always_comb begin
        ent0_nxt = ent0;
        ent1_nxt = ent1;
        cnt_nxt  = buf_cnt + 2'(push) - 2'(pop);
        case ({push, pop})
            2'b10: begin
                if (buf_cnt == 2'd0) ent0_nxt = push_data;
                else                 ent1_nxt = push_data;
            end
            2'b01: begin
                ent0_nxt = ent1;
            end
            2'b11: begin
                if (buf_cnt == 2'd1) begin
                    ent0_nxt = push_data;
                end else begin
                    ent0_nxt = ent1;
                    ent1_nxt = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ent0      <= '0;
            ent1      <= '0;
            buf_cnt   <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            ent0      <= ent0_nxt;
            ent1      <= ent1_nxt;
            buf_cnt   <= cnt_nxt;
            out_valid <= (cnt_nxt != 2'd0);
        end
    end

    assign out_data = ent0;

endmodule

// File: rtl/fifo_share_ctrl.sv
// Two-producer round-robin writer and rdreq sequencer around one shared non-showahead FIFO.
// Define ARB_WMARK_EN to throttle in1 while FIFO usedw is at or above WMARK.
module fifo_share_ctrl
    import fifo_share_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned UW    = UW_DEF,
    parameter int unsigned WMARK = WMARK_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [DW-1:0] fifo_data,
    output logic          fifo_wrreq,
    input  logic          fifo_full,
    output logic          fifo_rdreq,
    input  logic [DW-1:0] fifo_q,
    input  logic          fifo_empty,
    input  logic [UW-1:0] fifo_usedw,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          wm_hit
);

    grant_e     grant;
    logic       last_gnt;
    logic       elig0;
    logic       elig1;
    logic       wm_q;
    logic       wm_level_c;
    logic       pop;
    logic       rd_pend;
    logic [1:0] buf_cnt;
    logic [2:0] occ;

    // Watermark level sampled once per cycle; in1 sees the registered copy.
    assign wm_level_c = (fifo_usedw >= UW'(WMARK));

`ifdef ARB_WMARK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wm_q <= 1'b0;
        else          wm_q <= wm_level_c;
    end
`else
    logic unused_wm_level;
    assign unused_wm_level = wm_level_c;
    assign wm_q            = 1'b0;
`endif

    assign wm_hit = wm_q;
    assign elig0  = in0_valid;
    assign elig1  = in1_valid & ~wm_q;

    // Round-robin: on a tie the producer that did not win last time is served.
    always_comb begin
        grant = GRANT_NONE;
        if (reset_n && !fifo_full) begin
            if (elig0 && elig1) begin
                grant = (last_gnt == GNT1) ? GRANT_IN0 : GRANT_IN1;
            end else if (elig0) begin
                grant = GRANT_IN0;
            end else if (elig1) begin
                grant = GRANT_IN1;
            end
        end
    end

    assign in0_ready  = (grant == GRANT_IN0);
    assign in1_ready  = (grant == GRANT_IN1);
    assign fifo_wrreq = (grant != GRANT_NONE);
    assign fifo_data  = (grant == GRANT_IN1) ? in1_data : in0_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= GNT1;
        end else if (grant == GRANT_IN0) begin
            last_gnt <= GNT0;
        end else if (grant == GRANT_IN1) begin
            last_gnt <= GNT1;
        end
    end

    // Read only while the buffer plus the word in flight leaves room after this cycle's pop.
    assign pop        = out_valid & out_ready;
    assign occ        = skid_occ(buf_cnt, rd_pend, pop);
    assign fifo_rdreq = reset_n & ~fifo_empty & (occ < 3'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= fifo_rdreq;
    end

    fifo_share_skid #(
        .DW (DW)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rd_pend),
        .push_data (fifo_q),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .buf_cnt   (buf_cnt)
    );

    a_occ_bound: assert property (@(posedge clock) disable iff (!reset_n)
        ({1'b0, buf_cnt} + {2'b00, rd_pend}) <= 3'd2);

    a_no_write_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(fifo_wrreq && fifo_full));

    a_no_read_empty: assert property (@(posedge clock) disable iff (!reset_n)
        !(fifo_rdreq && fifo_empty));

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl with a behavioural 256x8 non-showahead FIFO and a word-order scoreboard.
module tb_fifo_share_ctrl;

    localparam int DW    = 8;
    localparam int UW    = 8;
    localparam int DEPTH = 256;
    localparam int WMARK = 192;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] in0_data = '0;
    logic          in0_valid = 1'b0;
    logic          in0_ready;
    logic [DW-1:0] in1_data = '0;
    logic          in1_valid = 1'b0;
    logic          in1_ready;
    logic [DW-1:0] fifo_data;
    logic          fifo_wrreq;
    logic          fifo_full;
    logic          fifo_rdreq;
    logic [DW-1:0] fifo_q;
    logic          fifo_empty;
    logic [UW-1:0] fifo_usedw;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          wm_hit;

    always #5 clock = ~clock;

    fifo_share_ctrl #(.DW(DW), .UW(UW), .WMARK(WMARK)) dut (
        .clock(clock), .reset_n(reset_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_usedw(fifo_usedw), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .wm_hit(wm_hit)
    );

    // Behavioural FIFO: cleared by the same reset, q valid the cycle after rdreq, usedw wraps at full.
    logic [DW-1:0] fmem [DEPTH];
    int  fcnt = 0;
    int  fwp  = 0;
    int  frp  = 0;
    logic f_rd;
    logic f_wr;
    assign f_rd       = fifo_rdreq && (fcnt != 0);
    assign f_wr       = fifo_wrreq && (fcnt != DEPTH);
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);
    assign fifo_usedw = 8'(fcnt);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt   <= 0;
            fwp    <= 0;
            frp    <= 0;
            fifo_q <= '0;
        end else begin
            if (f_rd) begin
                fifo_q <= fmem[frp];
                frp    <= (frp + 1) % DEPTH;
            end
            if (f_wr) begin
                fmem[fwp] <= fifo_data;
                fwp       <= (fwp + 1) % DEPTH;
            end
            fcnt <= fcnt + (f_wr ? 1 : 0) - (f_rd ? 1 : 0);
        end
    end

    // Reference model state: words accepted but not yet delivered, in delivery order.
    logic [DW-1:0] exp_q [$];
    int  inflight;
    bit  rd_last;
    bit  last_w;
    bit  wm_exp;
    int  checks = 0;
    int  errors = 0;

    bit  e_rdy0, e_rdy1, e_rdreq, e_ovalid, e_pop, e_wm;
    logic [DW-1:0] e_odata;

    task automatic model_reset();
        exp_q.delete();
        inflight = 0;
        rd_last  = 1'b0;
        last_w   = 1'b1;
        wm_exp   = 1'b0;
    endtask

    // Drive one cycle of stimulus and compute the expected response for it.
    task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1,
                        input logic [DW-1:0] d1, input bit ordy);
        bit el0, el1, wnxt;
        @(negedge clock);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
        #1;
        e_wm   = wm_exp;
        el0    = v0;
        el1    = v1 && !wm_exp;
        e_rdy0 = 1'b0;
        e_rdy1 = 1'b0;
        if (!fifo_full) begin
            if (el0 && el1) begin
                if (last_w) e_rdy0 = 1'b1;
                else        e_rdy1 = 1'b1;
            end else if (el0) begin
                e_rdy0 = 1'b1;
            end else if (el1) begin
                e_rdy1 = 1'b1;
            end
        end
        e_ovalid = (inflight - (rd_last ? 1 : 0)) > 0;
        e_pop    = e_ovalid && ordy;
        e_odata  = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        e_rdreq  = !fifo_empty && ((inflight - (e_pop ? 1 : 0)) < 2);
`ifdef ARB_WMARK_EN
        wnxt = (fifo_usedw >= 8'(WMARK));
`else
        wnxt = 1'b0;
`endif
        if (e_pop) begin
            void'(exp_q.pop_front());
            inflight--;
        end
        if (e_rdreq) inflight++;
        rd_last = e_rdreq;
        if (e_rdy0) begin exp_q.push_back(d0); last_w = 1'b0; end
        if (e_rdy1) begin exp_q.push_back(d1); last_w = 1'b1; end
        wm_exp = wnxt;
    endtask

    task automatic drain_and_check(input string tag, input bit toggle);
        bit ordy = 1'b1;
        int n = 0;
        while ((exp_q.size() != 0 || inflight != 0) && n < 1200) begin
            step(1'b0, 8'h00, 1'b0, 8'h00, ordy);
            checks++; if (out_valid !== e_ovalid) begin errors++; $display("FAIL %s_drain_ovalid cyc %0d got %b exp %b", tag, n, out_valid, e_ovalid); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL %s_drain_data cyc %0d got %h exp %h", tag, n, out_data, e_odata); end
            end
            checks++; if (fifo_rdreq !== e_rdreq) begin errors++; $display("FAIL %s_drain_rdreq cyc %0d got %b exp %b", tag, n, fifo_rdreq, e_rdreq); end
            n++;
            if (toggle) ordy = !ordy;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain_timeout left %0d exp 0", tag, exp_q.size()); end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_odata got %h exp 00", out_data); end
        checks++; if (wm_hit !== 1'b0) begin errors++; $display("FAIL rst_wm got %b exp 0", wm_hit); end
        checks++; if ({in0_ready, in1_ready, fifo_wrreq, fifo_rdreq} !== 4'b0000) begin errors++; $display("FAIL rst_req got %b exp 0000", {in0_ready, in1_ready, fifo_wrreq, fifo_rdreq}); end
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] outs [$];
        logic [DW-1:0] want [4];
        logic [DW-1:0] n0 = 8'h00;
        logic [DW-1:0] n1 = 8'h80;
        want[0] = 8'h00; want[1] = 8'h80; want[2] = 8'h01; want[3] = 8'h81;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, n0, 1'b1, n1, 1'b1);
            checks++; if (in0_ready !== e_rdy0) begin errors++; $display("FAIL rr_rdy0 cyc %0d got %b exp %b", i, in0_ready, e_rdy0); end
            checks++; if (in1_ready !== e_rdy1) begin errors++; $display("FAIL rr_rdy1 cyc %0d got %b exp %b", i, in1_ready, e_rdy1); end
            checks++; if (out_valid !== e_ovalid) begin errors++; $display("FAIL rr_ovalid cyc %0d got %b exp %b", i, out_valid, e_ovalid); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL rr_data cyc %0d got %h exp %h", i, out_data, e_odata); end
            end
            if (out_valid && out_ready) outs.push_back(out_data);
            if (e_rdy0) n0 = n0 + 8'd1;
            if (e_rdy1) n1 = n1 + 8'd1;
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (outs.size() <= k || outs[k] !== want[k]) begin errors++; $display("FAIL rr_order idx %0d got %h exp %h", k, (outs.size() > k) ? outs[k] : 8'hxx, want[k]); end
        end
        drain_and_check("rr", 1'b0);
    endtask

    task automatic test_fill_full();
        int acc = 0, pops = 0, first = -1, last = -1;
        logic [DW-1:0] n0 = 8'h10;
        logic [DW-1:0] n1 = 8'hc0;
        for (int i = 0; i < 400 && !fifo_full; i++) begin
            step(1'b1, n0, 1'b1, n1, 1'b0);
            checks++; if ({in0_ready, in1_ready} !== {e_rdy0, e_rdy1}) begin errors++; $display("FAIL fill_rdy cyc %0d got %b exp %b", i, {in0_ready, in1_ready}, {e_rdy0, e_rdy1}); end
            checks++; if (fifo_rdreq !== e_rdreq) begin errors++; $display("FAIL fill_rdreq cyc %0d got %b exp %b", i, fifo_rdreq, e_rdreq); end
            if (in0_ready || in1_ready) acc++;
            if (e_rdy0) n0 = n0 + 8'd1;
            if (e_rdy1) n1 = n1 + 8'd1;
        end
        step(1'b1, n0, 1'b1, n1, 1'b0);
        checks++; if ({in0_ready, in1_ready, fifo_wrreq} !== 3'b000) begin errors++; $display("FAIL full_ready got %b exp 000", {in0_ready, in1_ready, fifo_wrreq}); end
        checks++; if (fcnt !== DEPTH) begin errors++; $display("FAIL full_fifo_words got %0d exp %0d", fcnt, DEPTH); end
        checks++; if (acc !== DEPTH + 2) begin errors++; $display("FAIL full_accepted got %0d exp %0d", acc, DEPTH + 2); end
        checks++; if ({out_valid, fifo_rdreq} !== 2'b10) begin errors++; $display("FAIL full_buffer got %b exp 10", {out_valid, fifo_rdreq}); end
        for (int i = 0; i < 400 && (exp_q.size() != 0 || inflight != 0); i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++; if (out_valid !== e_ovalid) begin errors++; $display("FAIL full_drain_ovalid cyc %0d got %b exp %b", i, out_valid, e_ovalid); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL full_drain_data cyc %0d got %h exp %h", i, out_data, e_odata); end
            end
            if (out_valid) begin
                pops++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++; if (pops !== DEPTH + 2) begin errors++; $display("FAIL full_drain_count got %0d exp %0d", pops, DEPTH + 2); end
        checks++; if (last - first + 1 !== DEPTH + 2) begin errors++; $display("FAIL full_drain_gapless span %0d exp %0d", last - first + 1, DEPTH + 2); end
    endtask

    task automatic test_toggle_ready();
        int acc = 0, pops = 0;
        bit ordy = 1'b1;
        for (int i = 0; i < 1000 && acc < 100; i++) begin
            step(($urandom_range(1) == 1), 8'($urandom), ($urandom_range(1) == 1), 8'($urandom), ordy);
            checks++; if ({in0_ready, in1_ready} !== {e_rdy0, e_rdy1}) begin errors++; $display("FAIL tog_rdy cyc %0d got %b exp %b", i, {in0_ready, in1_ready}, {e_rdy0, e_rdy1}); end
            checks++; if (fifo_rdreq !== e_rdreq) begin errors++; $display("FAIL tog_rdreq cyc %0d got %b exp %b", i, fifo_rdreq, e_rdreq); end
            checks++; if (out_valid !== e_ovalid) begin errors++; $display("FAIL tog_ovalid cyc %0d got %b exp %b", i, out_valid, e_ovalid); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL tog_data cyc %0d got %h exp %h", i, out_data, e_odata); end
            end
            if (e_rdy0 || e_rdy1) acc++;
            if (e_pop) pops++;
            ordy = !ordy;
        end
        drain_and_check("tog", 1'b1);
        checks++; if (acc < 100) begin errors++; $display("FAIL tog_accepted got %0d exp >=100", acc); end
    endtask

    task automatic test_first_word_latency();
        step(1'b1, 8'h5a, 1'b0, 8'h00, 1'b1);
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got %b exp 1", in0_ready); end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++; if ({fifo_empty, out_valid} !== 2'b00) begin errors++; $display("FAIL lat_c0 empty/ovalid got %b exp 00", {fifo_empty, out_valid}); end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1 ovalid got %b exp 0", out_valid); end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_c2 ovalid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'h5a) begin errors++; $display("FAIL lat_c2 data got %h exp 5a", out_data); end
        drain_and_check("lat", 1'b0);
    endtask

    task automatic test_watermark();
        bit resumed = 1'b0;
`ifdef ARB_WMARK_EN
        bit wm_high = 1'b1;
`else
        bit wm_high = 1'b0;
`endif
        for (int i = 0; i < 400 && fcnt < 200; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
            checks++; if (wm_hit !== e_wm) begin errors++; $display("FAIL wm_fill_hit cyc %0d got %b exp %b", i, wm_hit, e_wm); end
            checks++; if ({in0_ready, in1_ready} !== {e_rdy0, e_rdy1}) begin errors++; $display("FAIL wm_fill_rdy cyc %0d got %b exp %b", i, {in0_ready, in1_ready}, {e_rdy0, e_rdy1}); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b0);
            checks++; if (wm_hit !== wm_high) begin errors++; $display("FAIL wm_high_hit cyc %0d got %b exp %b", i, wm_hit, wm_high); end
            checks++; if (in1_ready !== !wm_high) begin errors++; $display("FAIL wm_high_rdy1 cyc %0d got %b exp %b", i, in1_ready, !wm_high); end
        end
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1);
            checks++; if (wm_hit !== e_wm) begin errors++; $display("FAIL wm_drain_hit cyc %0d got %b exp %b", i, wm_hit, e_wm); end
            checks++; if (in1_ready !== e_rdy1) begin errors++; $display("FAIL wm_drain_rdy1 cyc %0d got %b exp %b", i, in1_ready, e_rdy1); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL wm_drain_data cyc %0d got %h exp %h", i, out_data, e_odata); end
            end
            if (in1_ready) resumed = 1'b1;
        end
        checks++; if (resumed !== 1'b1) begin errors++; $display("FAIL wm_resume got %b exp 1", resumed); end
        drain_and_check("wm", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(9) > 2));
            checks++; if ({in0_ready, in1_ready} !== {e_rdy0, e_rdy1}) begin errors++; $display("FAIL rnd_rdy cyc %0d got %b exp %b", i, {in0_ready, in1_ready}, {e_rdy0, e_rdy1}); end
            checks++; if (fifo_rdreq !== e_rdreq) begin errors++; $display("FAIL rnd_rdreq cyc %0d got %b exp %b", i, fifo_rdreq, e_rdreq); end
            checks++; if (out_valid !== e_ovalid) begin errors++; $display("FAIL rnd_ovalid cyc %0d got %b exp %b", i, out_valid, e_ovalid); end
            if (e_ovalid) begin
                checks++; if (out_data !== e_odata) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, out_data, e_odata); end
            end
        end
        drain_and_check("rnd", 1'b0);
    endtask

    task automatic test_reset_midstream();
        int i = 0;
        for (i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1);
            if (e_rdreq) break;
        end
        checks++; if (i >= 20) begin errors++; $display("FAIL mid_no_rdreq within %0d cycles", i); end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ovalid got %b exp 0", out_valid); end
        checks++; if ({in0_ready, in1_ready, fifo_wrreq, fifo_rdreq} !== 4'b0000) begin errors++; $display("FAIL mid_req got %b exp 0000", {in0_ready, in1_ready, fifo_wrreq, fifo_rdreq}); end
        model_reset();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 8'ha0, 1'b1, 8'hb0, 1'b1);
        checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL mid_first_tie got %b exp 10", {in0_ready, in1_ready}); end
        step(1'b1, 8'ha1, 1'b1, 8'hb0, 1'b1);
        checks++; if ({in0_ready, in1_ready} !== 2'b01) begin errors++; $display("FAIL mid_second_tie got %b exp 01", {in0_ready, in1_ready}); end
        drain_and_check("mid", 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fill_full();
        test_toggle_ready();
        test_first_word_latency();
        test_watermark();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
